snake_dir_ctrl: RTL
===================

# snake_dir_ctrl

Direction controller and step scheduler for the snake game core. Conditions the four raw button inputs and arbitrates simultaneous presses into one direction, rejecting 180° reversals. Paces the game with a fixed-period listen window and hands each movement step to the snake datapath over a valid/ready handshake. It sits between the board buttons and the snake datapath, and drives the `is_listening` window that benches synchronise to.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed before a synchronised button level is accepted; must be ≥2.
- `TICK_CYCLES`, 1000: length in clk cycles of each listen window; must be ≥2.
- `clk  in  1`: single system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `up, down, left, right  in  1 each`: raw asynchronous buttons, active-high.
- `game_over  in  1`: pulse from datapath; aborts play.
- `step_ready  in  1`: datapath accepts a step.
- `step_valid  out  1`: a step with direction `dir` is offered.
- `dir  out  2`: committed direction; UP=0, DOWN=1, LEFT=2, RIGHT=3.
- `is_listening  out  1`: high while button presses are being accepted.
- `running  out  1`: high when not in IDLE.

## Operation
- Conditioning, per button:
  - 2-flop synchroniser, then a debouncer.
  - The debounced level takes the synchronised value once it has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles.
  - Any mismatch gap restarts the count.
  - A press event is a 1-cycle pulse on the debounced rising edge; releases generate nothing.
- Arbitration: if several press events occur in the same cycle, priority is UP > DOWN > LEFT > RIGHT.
- Reversal rule: a press whose direction is the opposite of the committed `dir` is discarded (UP↔DOWN, LEFT↔RIGHT). A press equal to `dir` is accepted (no-op).
- FSM states:
  - IDLE: `running`=0. Any press event sets `dir` to the pressed direction immediately, with no reversal check, and moves to LISTEN with the counter at 0.
  - LISTEN: `is_listening`=1, counter runs 0..TICK_CYCLES-1.
    - Each accepted press overwrites `pending`; the latest press wins.
    - `pending` is loaded with `dir` on LISTEN entry.
    - At count TICK_CYCLES-1: `dir` <= `pending`, then move to STEP.
  - STEP: `step_valid`=1, `dir` stable. On `step_valid && step_ready`, move to LISTEN with the counter at 0. Press events in STEP are dropped.
- `game_over` = 1 in any state → IDLE at the next edge. This is the only case where `step_valid` may drop without a handshake. In the same cycle, `game_over` takes precedence over a press or handshake.
- Reversal in LISTEN is checked against the committed `dir`, not against `pending`.

## Timing
- Reset values: `dir`=RIGHT (2'd3), `step_valid`=0, `is_listening`=0, `running`=0. FSM=IDLE, counters=0, debounced levels=0, synchronisers=0.
- Reset is asynchronous in effect. Reset mid-step drops `step_valid` immediately and discards `pending`.
- Press latency: a raw input held high from edge N produces its press event at edge N+2+DEBOUNCE_CYCLES, and that event is sampled into `pending` on the same edge.
- LISTEN lasts exactly TICK_CYCLES cycles. `step_valid` rises on the edge after the last LISTEN cycle, together with the new `dir`.
- If `step_ready` is already high, STEP lasts 1 cycle, so the step period is TICK_CYCLES+1. Each stall cycle extends the period by 1.
- A press event in the last LISTEN cycle is included in that commit.
- All outputs are registered.

## Structure
- `snake_pkg`:
  - `dir_t` enum {UP, DOWN, LEFT, RIGHT} (2 bits, values as above).
  - `opposite(dir_t)` function.
  - `ctrl_state_t` {IDLE, LISTEN, STEP}.
  - Shared with the snake datapath.
- Sub-module `btn_debounce` (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, press) contains the synchroniser, counter and edge detect. It is instantiated 4×.
- The counter width is `$clog2` of each parameter.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, TICK_CYCLES=20.
- Reset, then hold `right` for 10 cycles:
  - `running` rises 6 edges after assertion; `dir`=3.
  - `is_listening`=1 for 20 cycles, then `step_valid`=1 with `dir`=3.
- Glitch: `up` high for 3 cycles, low for 1, then high for 3, all in LISTEN → no press event; `dir` unchanged at the next step.
- Reversal, starting with `dir`=RIGHT in LISTEN:
  - Press LEFT → next step `dir`=3.
  - Press UP, then LEFT in the same window → next step `dir`=0.
- Simultaneous `down` and `left` edges in one cycle with `dir`=RIGHT → next step `dir`=1.
- Backpressure: hold `step_ready`=0 for 7 cycles in STEP → `step_valid` and `dir` stable throughout; the next LISTEN starts the cycle after the handshake.
- `game_over` pulse while `step_valid`=1 → next edge `step_valid`=0, `running`=0, `dir` retained. Deasserting `rst` mid-LISTEN → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg
// Types and helpers shared by the snake direction controller and the snake
// datapath.
//   dir_t        : movement direction, UP=0, DOWN=1, LEFT=2, RIGHT=3
//   ctrl_state_t : controller FSM state {IDLE, LISTEN, STEP}
//   opposite()   : returns the 180-degree reverse of a direction
package snake_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    STEP   = 2'd2
  } ctrl_state_t;

  localparam int NUM_BTNS = 4;

  function automatic dir_t opposite(input dir_t d);
    dir_t r;
    case (d)
      UP:      r = DOWN;
      DOWN:    r = UP;
      LEFT:    r = RIGHT;
      default: r = LEFT;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_btn_debounce.sv
// btn_debounce
// Conditions one raw asynchronous button: 2-flop synchroniser, debouncer and
// rising-edge detector.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   raw   : raw asynchronous button, active-high
//   level : debounced button level
//   press : one-cycle registered pulse on each debounced rising edge
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // The count holds the number of consecutive cycles the synchronised value
  // has already differed from the debounced level; the level flips on the
  // cycle that would make it DEBOUNCE_CYCLES. Any agreeing cycle restarts it.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl
// Direction controller and step scheduler for the snake game core.
// Debounces the four buttons, arbitrates presses (UP > DOWN > LEFT > RIGHT),
// rejects 180-degree reversals, paces play with a fixed listen window and
// offers each step to the datapath over a valid/ready handshake.
//   clk          : system clock
//   rst          : asynchronous active-low reset
//   up/down/left/right : raw buttons, active-high
//   game_over    : abort play, return to IDLE (highest precedence)
//   step_ready   : datapath accepts the offered step
//   step_valid   : a step in direction dir is offered
//   dir          : committed direction (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   is_listening : high while presses are accepted
//   running      : high when not IDLE
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_CYCLES     = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       game_over,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] dir,
  output logic       is_listening,
  output logic       running
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  // Button vector indexed by direction encoding.
  logic [NUM_BTNS-1:0] raw_vec;
  logic [NUM_BTNS-1:0] level_vec;
  logic [NUM_BTNS-1:0] press_raw_vec;
  logic [NUM_BTNS-1:0] press_vec;

  assign raw_vec = {right, left, down, up};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi]),
        .press(press_raw_vec[gi])
      );
      // A press pulse always coincides with a high debounced level.
      assign press_vec[gi] = press_raw_vec[gi] & level_vec[gi];
    end
  endgenerate

  // Fixed-priority arbitration of same-cycle presses.
  logic any_press;
  dir_t arb_dir;

  always_comb begin
    any_press = |press_vec;
    if (press_vec[0])      arb_dir = UP;
    else if (press_vec[1]) arb_dir = DOWN;
    else if (press_vec[2]) arb_dir = LEFT;
    else                   arb_dir = RIGHT;
  end

  ctrl_state_t   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  dir_t          dir_q, dir_d;
  dir_t          pending_q, pending_d;
  logic          step_valid_q, step_valid_d;
  logic          is_listening_q, is_listening_d;
  logic          running_q, running_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    pending_d = pending_q;

    case (state_q)
      IDLE: begin
        // Starting move is taken as-is; there is no previous heading yet.
        if (any_press) begin
          dir_d     = arb_dir;
          pending_d = arb_dir;
          cnt_d     = '0;
          state_d   = LISTEN;
        end
      end
      LISTEN: begin
        // Reversal is judged against the committed heading, not pending.
        if (any_press && (arb_dir != opposite(dir_q))) begin
          pending_d = arb_dir;
        end
        if (cnt_q == TW'(TICK_CYCLES - 1)) begin
          dir_d   = pending_d;
          state_d = STEP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP: begin
        if (step_ready) begin
          state_d   = LISTEN;
          cnt_d     = '0;
          pending_d = dir_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // game_over outranks any press or handshake in the same cycle.
    if (game_over) begin
      state_d   = IDLE;
      cnt_d     = '0;
      dir_d     = dir_q;
      pending_d = pending_q;
    end

    step_valid_d   = (state_d == STEP);
    is_listening_d = (state_d == LISTEN);
    running_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      dir_q          <= RIGHT;
      pending_q      <= RIGHT;
      step_valid_q   <= 1'b0;
      is_listening_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dir_q          <= dir_d;
      pending_q      <= pending_d;
      step_valid_q   <= step_valid_d;
      is_listening_q <= is_listening_d;
      running_q      <= running_d;
    end
  end

  assign step_valid   = step_valid_q;
  assign dir          = dir_q;
  assign is_listening = is_listening_q;
  assign running      = running_q;

endmodule
